// File: rtl/keypad_pkg.sv
// keypad_pkg: key map, sequencer states and key classification helper
package keypad_pkg;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hF;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, APPLY, RELEASE} state_t;
  function automatic logic is_digit(input logic [3:0] code);
    return code < 4'hA;
  endfunction
endpackage

// File: rtl/keypad_stable_cnt.sv
// keypad_stable_cnt: saturating stable-sample counter, clr has priority over inc
module keypad_stable_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounced keypad sequencer, BCD entry buffer and valid/ready commit
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key_code,
  input  logic                           key_pressed,
  output logic [4*N_DIGITS-1:0]          buf_digits,
  output logic [$clog2(N_DIGITS+1)-1:0]  digit_cnt,
  output logic                           key_event,
  output logic [4*N_DIGITS-1:0]          entry_value,
  output logic                           entry_valid,
  input  logic                           entry_ready
);
  localparam int BW = 4*N_DIGITS;
  localparam int CW = $clog2(N_DIGITS+1);
  localparam int DW = $clog2(DEBOUNCE_CYC+1);
  state_t state;
  logic [3:0] code_q;
  logic [DW-1:0] db_cnt, rel_cnt;
  logic match, db_done, rel_done;
  assign match    = key_pressed && key_code == code_q;
  assign db_done  = db_cnt == DW'(DEBOUNCE_CYC-1);
  assign rel_done = rel_cnt == DW'(DEBOUNCE_CYC-1);
  keypad_stable_cnt #(.W(DW)) u_press (
    .clk(clk), .rst(rst), .clr(state != DEBOUNCE), .inc(match), .cnt(db_cnt)
  );
  // release qualification restarts on any pressed sample
  keypad_stable_cnt #(.W(DW)) u_release (
    .clk(clk), .rst(rst), .clr(state != RELEASE || key_pressed), .inc(1'b1), .cnt(rel_cnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      code_q      <= '0;
      buf_digits  <= '0;
      digit_cnt   <= '0;
      key_event   <= 1'b0;
      entry_value <= '0;
      entry_valid <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (entry_valid && entry_ready) entry_valid <= 1'b0;
      case (state)
        IDLE: if (key_pressed) begin
          code_q <= key_code;
          state  <= DEBOUNCE;
        end
        DEBOUNCE: state <= !match ? IDLE : db_done ? APPLY : DEBOUNCE;
        APPLY: begin
          key_event <= 1'b1;
          state     <= RELEASE;
          if (is_digit(code_q)) begin
            if (digit_cnt != CW'(N_DIGITS)) begin
              buf_digits <= (buf_digits << 4) | BW'(code_q);
              digit_cnt  <= digit_cnt + CW'(1);
            end
          end else if (code_q == KEY_CLR) begin
            buf_digits <= '0;
            digit_cnt  <= '0;
          end else if (code_q == KEY_BS) begin
            if (digit_cnt != '0) begin
              buf_digits <= buf_digits >> 4;
              digit_cnt  <= digit_cnt - CW'(1);
            end
          end else if (code_q == KEY_ENT) begin
            // a commit while the consumer is accepting reloads valid back-to-back
            if (digit_cnt != '0 && (!entry_valid || entry_ready)) begin
              entry_value <= buf_digits;
              entry_valid <= 1'b1;
              buf_digits  <= '0;
              digit_cnt   <= '0;
            end
          end
        end
        RELEASE: if (!key_pressed && rel_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed scenarios for the keypad entry sequencer
module tb_keypad_entry_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_code = '0;
  logic        key_pressed = 1'b0;
  logic [15:0] buf_digits;
  logic [2:0]  digit_cnt;
  logic        key_event;
  logic [15:0] entry_value;
  logic        entry_valid;
  logic        entry_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  int nev, first, tot;

  keypad_entry_ctrl #(.N_DIGITS(4), .DEBOUNCE_CYC(16)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_pressed(key_pressed),
    .buf_digits(buf_digits), .digit_cnt(digit_cnt), .key_event(key_event),
    .entry_value(entry_value), .entry_valid(entry_valid), .entry_ready(entry_ready)
  );

  always #5 clk = ~clk;

  // press c for hold samples, release for rel samples; pulse ready into edge rdy_at
  task automatic key(input logic [3:0] c, input int hold, input int rel, input int rdy_at,
                     output int n, output int f);
    n = 0;
    f = -1;
    key_code = c;
    key_pressed = 1'b1;
    for (int i = 1; i <= hold + rel; i++) begin
      @(negedge clk);
      if (key_event) begin
        n++;
        if (f < 0) f = i - 1;
      end
      if (i == hold) key_pressed = 1'b0;
      entry_ready = (i == rdy_at);
    end
  endtask

  task automatic tap(input logic [3:0] c);
    key(c, 20, 20, -1, nev, first);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (buf_digits !== 16'h0 || digit_cnt !== 3'd0 || key_event !== 1'b0 ||
        entry_value !== 16'h0 || entry_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: buf=%h cnt=%0d ev=%b val=%h vld=%b, want all 0",
               buf_digits, digit_cnt, key_event, entry_value, entry_valid);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    key(4'h1, 40, 40, -1, nev, first);
    checks++;
    if (nev !== 1 || first !== 17) begin
      errors++;
      $display("FAIL single_timing: events=%0d first=%0d, want 1 at 17", nev, first);
    end
    checks++;
    if (buf_digits !== 16'h0001 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_buf: buf=%h cnt=%0d, want 0001 1", buf_digits, digit_cnt);
    end
    tap(4'hA);
  endtask

  task automatic test_bounce;
    key_code = 4'h5;
    key_pressed = 1'b1;
    tot = 0;
    repeat (5) begin
      @(negedge clk);
      if (key_event) tot++;
    end
    key(4'h3, 30, 20, -1, nev, first);
    tot += nev;
    checks++;
    if (tot !== 1 || buf_digits !== 16'h0003) begin
      errors++;
      $display("FAIL bounce: events=%0d buf=%h, want 1 0003", tot, buf_digits);
    end
    tap(4'hA);
  endtask

  task automatic test_edit;
    tot = 0;
    for (int d = 1; d <= 5; d++) begin
      tap(4'(d));
      tot += nev;
    end
    checks++;
    if (tot !== 5 || buf_digits !== 16'h1234 || digit_cnt !== 3'd4) begin
      errors++;
      $display("FAIL fill: events=%0d buf=%h cnt=%0d, want 5 1234 4", tot, buf_digits, digit_cnt);
    end
    tap(4'hB);
    checks++;
    if (buf_digits !== 16'h0123 || digit_cnt !== 3'd3) begin
      errors++;
      $display("FAIL backspace: buf=%h cnt=%0d, want 0123 3", buf_digits, digit_cnt);
    end
    tap(4'hC);
    checks++;
    if (nev !== 1 || buf_digits !== 16'h0123) begin
      errors++;
      $display("FAIL ignored_key: events=%0d buf=%h, want 1 0123", nev, buf_digits);
    end
    tap(4'hA);
    checks++;
    if (buf_digits !== 16'h0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL clear: buf=%h cnt=%0d, want 0 0", buf_digits, digit_cnt);
    end
    tap(4'hB);
    checks++;
    if (nev !== 1 || buf_digits !== 16'h0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL bs_empty: events=%0d buf=%h cnt=%0d, want 1 0 0", nev, buf_digits, digit_cnt);
    end
  endtask

  task automatic test_commit;
    tap(4'h9);
    tap(4'h8);
    tap(4'hF);
    checks++;
    if (entry_valid !== 1'b1 || entry_value !== 16'h0098 || buf_digits !== 16'h0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL commit: vld=%b val=%h buf=%h cnt=%0d, want 1 0098 0 0",
               entry_valid, entry_value, buf_digits, digit_cnt);
    end
    tot = 0;
    repeat (50) begin
      @(negedge clk);
      if (entry_valid !== 1'b1) tot++;
    end
    checks++;
    if (tot !== 0) begin
      errors++;
      $display("FAIL hold_valid: dropped in %0d cycles, want 0", tot);
    end
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    checks++;
    if (entry_valid !== 1'b0 || entry_value !== 16'h0098) begin
      errors++;
      $display("FAIL accept: vld=%b val=%h, want 0 0098", entry_valid, entry_value);
    end
  endtask

  task automatic test_back_to_back;
    tap(4'h4);
    tap(4'h2);
    tap(4'hF);
    tap(4'h7);
    tap(4'hF);
    checks++;
    if (nev !== 1 || entry_value !== 16'h0042 || entry_valid !== 1'b1 || buf_digits !== 16'h0007) begin
      errors++;
      $display("FAIL blocked_ent: events=%0d val=%h vld=%b buf=%h, want 1 0042 1 0007",
               nev, entry_value, entry_valid, buf_digits);
    end
    key(4'hF, 20, 20, 17, nev, first);
    checks++;
    if (entry_value !== 16'h0007 || entry_valid !== 1'b1 || buf_digits !== 16'h0) begin
      errors++;
      $display("FAIL back_to_back: val=%h vld=%b buf=%h, want 0007 1 0", entry_value, entry_valid, buf_digits);
    end
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
  endtask

  task automatic test_empty_ent;
    tap(4'hF);
    checks++;
    if (nev !== 1 || entry_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_ent: events=%0d vld=%b, want 1 0", nev, entry_valid);
    end
  endtask

  task automatic test_async_reset;
    tap(4'h4);
    tap(4'h2);
    tap(4'hF);
    key_code = 4'h5;
    key_pressed = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (buf_digits !== 16'h0 || digit_cnt !== 3'd0 || key_event !== 1'b0 ||
        entry_value !== 16'h0 || entry_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: buf=%h cnt=%0d ev=%b val=%h vld=%b, want all 0",
               buf_digits, digit_cnt, key_event, entry_value, entry_valid);
    end
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tot = 0;
    repeat (30) begin
      @(negedge clk);
      if (key_event) tot++;
    end
    checks++;
    if (tot !== 0 || buf_digits !== 16'h0 || entry_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: events=%0d buf=%h vld=%b, want 0 0 0", tot, buf_digits, entry_valid);
    end
    tap(4'h6);
    checks++;
    if (nev !== 1 || buf_digits !== 16'h0006 || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL fresh_press: events=%0d buf=%h cnt=%0d, want 1 0006 1", nev, buf_digits, digit_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_bounce();
    test_edit();
    test_commit();
    test_back_to_back();
    test_empty_ent();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
